itch_msg_sequencer: RTL

ITCH_MSG_SEQUENCER -- requirements
Module: itch_msg_sequencer

---
 rtl/itch_msg_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/itch_msg_sequencer.sv
// itch_msg_sequencer: splits a MoldUDP64 payload stream into length-prefixed ITCH message bodies
//
// Ports:
//   clkIn           sole clock, rising edge
//   rstIn           active-low reset, asynchronous assert, synchronised release
//   itchDataIn      payload byte, qualified by itchDataValidIn (no backpressure)
//   frameEndIn      one-cycle pulse closing the current frame
//   packetLostIn    one-cycle pulse from the upstream sequence-gap detector
//   msgDataOut      message body byte, qualified by msgValidOut
//   msgStartOut     first body byte (ITCH type byte)
//   msgEndOut       last body byte
//   msgTypeOut      type byte of the current message, held until the next start
//   lenErrOut       pulse: zero length or length above MAX_MSG_LEN
//   framingErrOut   pulse: frame ended inside a length field or a body
//   frameDoneOut    pulse one cycle after frameEndIn
//   frameMsgCntOut  completed messages in the last frame, held
//   lostCntOut      saturating count of packetLostIn pulses
module itch_msg_sequencer #(
   parameter logic [15:0] MAX_MSG_LEN = 16'd64
) (
   input  logic        clkIn,
   input  logic        rstIn,
   input  logic [7:0]  itchDataIn,
   input  logic        itchDataValidIn,
   input  logic        frameEndIn,
   input  logic        packetLostIn,
   output logic [7:0]  msgDataOut,
   output logic        msgValidOut,
   output logic        msgStartOut,
   output logic        msgEndOut,
   output logic [7:0]  msgTypeOut,
   output logic        lenErrOut,
   output logic        framingErrOut,
   output logic        frameDoneOut,
   output logic [15:0] frameMsgCntOut,
   output logic [15:0] lostCntOut
);
   typedef enum logic [1:0] {LEN_HI, LEN_LO, BODY, DROP} state_t;

   state_t      r_state;
   state_t      w_state_byte;
   logic [1:0]  r_rst_sync;
   logic        w_rst_n;
   logic [7:0]  r_len_hi;
   logic [15:0] r_rem;
   logic        r_first;
   logic [15:0] r_frame_cnt;
   logic [15:0] w_cnt_inc;
   logic [15:0] w_len;
   logic        w_len_bad;
   logic        w_last;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_start;
   logic        r_end;
   logic [7:0]  r_type;
   logic        r_len_err;
   logic        r_framing_err;
   logic        r_frame_done;
   logic [15:0] r_frame_msg_cnt;
   logic [15:0] r_lost_cnt;

   // Reset asserts immediately but releases only after two clean clock edges
   always_ff @(posedge clkIn or negedge rstIn) begin
      if (!rstIn) r_rst_sync <= 2'b00;
      else        r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   // Byte processing is resolved first so that a coincident frameEndIn sees
   // the post-byte state and a message completed on that same byte
   always_comb begin
      w_len        = {r_len_hi, itchDataIn};
      w_len_bad    = (w_len == 16'd0) || (w_len > MAX_MSG_LEN);
      w_last       = itchDataValidIn && (r_state == BODY) && (r_rem == 16'd1);
      w_cnt_inc    = (w_last && r_frame_cnt != 16'hFFFF) ? r_frame_cnt + 16'd1 : r_frame_cnt;
      w_state_byte = r_state;
      if (itchDataValidIn) begin
         case (r_state)
            LEN_HI:  w_state_byte = LEN_LO;
            LEN_LO:  w_state_byte = (w_len == 16'd0) ? LEN_HI : (w_len > MAX_MSG_LEN) ? DROP : BODY;
            BODY:    w_state_byte = w_last ? LEN_HI : BODY;
            default: w_state_byte = DROP;
         endcase
      end
   end

   always_ff @(posedge clkIn or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state         <= LEN_HI;
         r_len_hi        <= 8'd0;
         r_rem           <= 16'd0;
         r_first         <= 1'b0;
         r_frame_cnt     <= 16'd0;
         r_data          <= 8'd0;
         r_valid         <= 1'b0;
         r_start         <= 1'b0;
         r_end           <= 1'b0;
         r_type          <= 8'd0;
         r_len_err       <= 1'b0;
         r_framing_err   <= 1'b0;
         r_frame_done    <= 1'b0;
         r_frame_msg_cnt <= 16'd0;
         r_lost_cnt      <= 16'd0;
      end else begin
         r_valid       <= 1'b0;
         r_start       <= 1'b0;
         r_end         <= 1'b0;
         r_len_err     <= 1'b0;
         r_framing_err <= 1'b0;
         r_frame_done  <= 1'b0;
         if (itchDataValidIn) begin
            case (r_state)
               LEN_HI: r_len_hi <= itchDataIn;
               LEN_LO: begin
                  r_len_err <= w_len_bad;
                  r_rem     <= w_len;
                  r_first   <= 1'b1;
               end
               BODY: begin
                  r_data  <= itchDataIn;
                  r_valid <= 1'b1;
                  r_start <= r_first;
                  r_end   <= w_last;
                  r_type  <= r_first ? itchDataIn : r_type;
                  r_first <= 1'b0;
                  r_rem   <= r_rem - 16'd1;
               end
               default: ;
            endcase
         end
         r_state     <= w_state_byte;
         r_frame_cnt <= w_cnt_inc;
         if (frameEndIn) begin
            r_state         <= LEN_HI;
            r_framing_err   <= (w_state_byte == LEN_LO) || (w_state_byte == BODY);
            r_frame_done    <= 1'b1;
            r_frame_msg_cnt <= w_cnt_inc;
            r_frame_cnt     <= 16'd0;
         end
         if (packetLostIn && r_lost_cnt != 16'hFFFF) r_lost_cnt <= r_lost_cnt + 16'd1;
      end
   end

   assign msgDataOut     = r_data;
   assign msgValidOut    = r_valid;
   assign msgStartOut    = r_start;
   assign msgEndOut      = r_end;
   assign msgTypeOut     = r_type;
   assign lenErrOut      = r_len_err;
   assign framingErrOut  = r_framing_err;
   assign frameDoneOut   = r_frame_done;
   assign frameMsgCntOut = r_frame_msg_cnt;
   assign lostCntOut     = r_lost_cnt;
endmodule
